// File: rtl/alu_result_monitor.sv
// alu_result_monitor
// Captures ALU result beats (y, zero, opcode) through a 2-entry valid/ready
// FIFO and forwards them to the consumer. Every accepted beat is also folded
// into a MISR signature and counted, and a sticky flag records any beat
// whose zero flag disagrees with its result value.
module alu_result_monitor #(
    parameter int                 WIDTH = 8,
    parameter int                 CNT_W = 16,
    parameter logic [WIDTH-1:0]   POLY  = 8'h1D,
    parameter logic [WIDTH-1:0]   SEED  = 8'hFF
) (
    input  logic                  clk,
    input  logic                  rst,
    // upstream (ALU) side
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_y,
    input  logic                  in_zero,
    input  logic [1:0]            in_opcode,
    // downstream (consumer) side
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_y,
    output logic                  out_zero,
    output logic [1:0]            out_opcode,
    // observation side
    input  logic                  clear,
    output logic [WIDTH-1:0]      signature,
    output logic [CNT_W-1:0]      result_count,
    output logic [CNT_W-1:0]      zero_count,
    output logic                  zero_mismatch
);

    typedef struct packed {
        logic [WIDTH-1:0] y;
        logic             zero;
        logic [1:0]       opcode;
    } beat_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Buffer state: r_head drives the outputs directly, r_tail holds the
    // second entry when the buffer is full.
    beat_t            r_head;
    beat_t            r_tail;
    logic [1:0]       r_count;

    // Observation state
    logic [WIDTH-1:0] r_sig;
    logic [CNT_W-1:0] r_result_count;
    logic [CNT_W-1:0] r_zero_count;
    logic             r_zero_mismatch;

    // Handshake and next-state wires
    beat_t            w_in_beat;
    logic             w_accept;
    logic             w_pop;
    logic [WIDTH-1:0] w_sig_base;
    logic [WIDTH-1:0] w_sig_next;
    logic [CNT_W-1:0] w_result_base;
    logic [CNT_W-1:0] w_zero_base;
    logic [CNT_W-1:0] w_result_next;
    logic [CNT_W-1:0] w_zero_next;
    logic             w_mismatch_base;
    logic             w_mismatch_next;
    logic             w_y_is_zero;

    assign w_in_beat = '{y: in_y, zero: in_zero, opcode: in_opcode};

    // in_ready comes only from registered occupancy, so a full buffer
    // refuses a beat even in a cycle where the head is being popped.
    assign in_ready  = (r_count < 2'd2);
    assign out_valid = (r_count != 2'd0);
    assign w_accept  = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    assign out_y      = r_head.y;
    assign out_zero   = r_head.zero;
    assign out_opcode = r_head.opcode;

    // 2-entry FIFO: push into the first free slot, pop shifts tail to head.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            // NOTE: the buffer entries are reset (not just the occupancy)
            // because out_y/out_zero/out_opcode must read zero after reset.
            r_count <= 2'd0;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            case ({w_accept, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_head <= w_in_beat;
                    end else begin
                        r_tail <= w_in_beat;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_head  <= r_tail;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    // Only reachable with one entry (in_ready is low when
                    // full), so the new beat becomes the head directly.
                    r_head <= w_in_beat;
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state for signature, counters and mismatch flag. clear selects
    // the post-clear values as the base so a beat accepted in the same
    // cycle is folded on top of the cleared state.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a variable unassigned, which would infer a latch.
        w_sig_base      = r_sig;
        w_result_base   = r_result_count;
        w_zero_base     = r_zero_count;
        w_mismatch_base = r_zero_mismatch;
        w_y_is_zero     = (in_y == {WIDTH{1'b0}});

        if (clear) begin
            w_sig_base      = SEED;
            w_result_base   = '0;
            w_zero_base     = '0;
            w_mismatch_base = 1'b0;
        end

        w_sig_next      = w_sig_base;
        w_result_next   = w_result_base;
        w_zero_next     = w_zero_base;
        w_mismatch_next = w_mismatch_base;

        if (w_accept) begin
            w_sig_next = {w_sig_base[WIDTH-2:0], 1'b0}
                       ^ (w_sig_base[WIDTH-1] ? POLY : {WIDTH{1'b0}})
                       ^ in_y;
            if (w_result_base != CNT_MAX) begin
                w_result_next = w_result_base + 1'b1;
            end
            if (in_zero && (w_zero_base != CNT_MAX)) begin
                w_zero_next = w_zero_base + 1'b1;
            end
            if (in_zero != w_y_is_zero) begin
                w_mismatch_next = 1'b1;
            end
        end
    end

    // Register signature, counters and sticky mismatch flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sig           <= SEED;
            r_result_count  <= '0;
            r_zero_count    <= '0;
            r_zero_mismatch <= 1'b0;
        end else begin
            r_sig           <= w_sig_next;
            r_result_count  <= w_result_next;
            r_zero_count    <= w_zero_next;
            r_zero_mismatch <= w_mismatch_next;
        end
    end

    assign signature     = r_sig;
    assign result_count  = r_result_count;
    assign zero_count    = r_zero_count;
    assign zero_mismatch = r_zero_mismatch;

endmodule

// File: tb/tb_alu_result_monitor.sv
// tb_alu_result_monitor
// Directed stimulus with hand-computed expectations. Accepted beats are
// pushed into a scoreboard queue; a separate monitor pops and compares
// whenever the DUT pops its head beat.
module tb_alu_result_monitor;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_y;
    logic        in_zero;
    logic [1:0]  in_opcode;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_y;
    logic        out_zero;
    logic [1:0]  out_opcode;
    logic        clear;
    logic [7:0]  signature;
    logic [15:0] result_count;
    logic [15:0] zero_count;
    logic        zero_mismatch;

    int n_tests = 0;
    int n_fail  = 0;

    // expected beat packed as {zero, opcode, y}
    logic [10:0] exp_q[$];

    alu_result_monitor dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_y          (in_y),
        .in_zero       (in_zero),
        .in_opcode     (in_opcode),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_y         (out_y),
        .out_zero      (out_zero),
        .out_opcode    (out_opcode),
        .clear         (clear),
        .signature     (signature),
        .result_count  (result_count),
        .zero_count    (zero_count),
        .zero_mismatch (zero_mismatch)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until accepted (bounded); records the
    // expected beat in the scoreboard at the cycle it is accepted.
    task automatic send(input logic [7:0] y, input logic z, input logic [1:0] op);
        bit done;
        done      = 1'b0;
        in_valid  = 1'b1;
        in_y      = y;
        in_zero   = z;
        in_opcode = op;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back({z, op, y});
                done = 1'b1;
            end
            tick();
        end
        in_valid = 1'b0;
        if (!done) check("send_timeout", 32'd0, 32'd1);
    endtask

    // Monitor: compares the head beat whenever the DUT is about to pop it.
    initial begin
        logic [10:0] e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", {21'd0, out_zero, out_opcode, out_y}, 32'h7FF);
                end else begin
                    e = exp_q.pop_front();
                    check("out_beat", {21'd0, out_zero, out_opcode, out_y}, {21'd0, e});
                end
            end
        end
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_y = '0; in_zero = 1'b0; in_opcode = '0;
        out_ready = 1'b0; clear = 1'b0;

        // 1. reset state
        tick(); tick();
        rst = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_signature", signature, 8'hFF);
        check("rst_result_count", result_count, 0);
        check("rst_zero_count", zero_count, 0);
        check("rst_mismatch", zero_mismatch, 0);
        check("rst_out_y", out_y, 0);

        // 2. basic flow and MISR folding
        out_ready = 1'b1;
        send(8'h03, 1'b0, 2'd1);
        check("t2_valid_1", out_valid, 1);
        check("t2_out_y_1", out_y, 8'h03);
        check("t2_sig_1", signature, 8'hE0);
        send(8'h00, 1'b1, 2'd2);
        check("t2_out_y_2", out_y, 8'h00);
        check("t2_out_zero_2", out_zero, 1);
        check("t2_sig_2", signature, 8'hDD);
        check("t2_result_count", result_count, 2);
        check("t2_zero_count", zero_count, 1);
        tick(); tick();
        check("t2_drained", out_valid, 0);

        // 3. backpressure: two fill the buffer, third stalls
        out_ready = 1'b0;
        send(8'h11, 1'b0, 2'd0);
        check("t3_ready_after_1", in_ready, 1);
        send(8'h22, 1'b0, 2'd1);
        check("t3_ready_full", in_ready, 0);
        in_valid = 1'b1; in_y = 8'h33; in_zero = 1'b0; in_opcode = 2'd2;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_stall_ready", in_ready, 0);
            check("t3_stall_count", result_count, 4);
            check("t3_stall_head", out_y, 8'h11);
        end

        // 4. full + in_valid + out_ready: pop only, accept next cycle
        out_ready = 1'b1;
        tick();
        check("t4_pop_only_count", result_count, 4);
        check("t4_pop_head", out_y, 8'h22);
        check("t4_ready_again", in_ready, 1);
        send(8'h33, 1'b0, 2'd2);
        check("t4_accept_count", result_count, 5);
        tick(); tick(); tick();
        check("t4_drained", out_valid, 0);

        // 5. sticky zero mismatch
        send(8'h05, 1'b1, 2'd3);
        check("t5_mismatch_set", zero_mismatch, 1);
        check("t5_zero_count", zero_count, 2);
        send(8'h07, 1'b0, 2'd0);
        send(8'h00, 1'b1, 2'd1);
        check("t5_mismatch_sticky", zero_mismatch, 1);
        check("t5_result_count", result_count, 8);

        // 6a. clear together with an accept
        clear = 1'b1;
        send(8'h03, 1'b0, 2'd1);
        clear = 1'b0;
        check("t6_clear_sig", signature, 8'hE0);
        check("t6_clear_result_count", result_count, 1);
        check("t6_clear_zero_count", zero_count, 0);
        check("t6_clear_mismatch", zero_mismatch, 0);
        tick(); tick(); tick();
        check("t6_drained", out_valid, 0);

        // 6b. reset with two queued beats and one beat on offer
        out_ready = 1'b0;
        send(8'hAA, 1'b0, 2'd1);
        send(8'hBB, 1'b0, 2'd2);
        check("t6_full_valid", out_valid, 1);
        check("t6_full_ready", in_ready, 0);
        rst = 1'b1;
        in_valid = 1'b1; in_y = 8'hCC; in_zero = 1'b0; in_opcode = 2'd3;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        check("t6_rst_valid", out_valid, 0);
        check("t6_rst_ready", in_ready, 1);
        check("t6_rst_sig", signature, 8'hFF);
        check("t6_rst_count", result_count, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t6_no_ghost", out_valid, 0);
        end

        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
